// File: rtl/fft_bitrev_loader.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// fft_bitrev_loader : writes a natural-order frame into a ping-pong buffer at
// bit-reversed addresses and streams it out in bit-reversed order. Rev 1.0
// =============================================================================
module fft_bitrev_loader #(
  parameter  int POINTS = 1024,
  parameter  int DATA_W = 32,
  localparam int ADDR_W = $clog2(POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(POINTS - 1);

  logic [DATA_W-1:0] mem_q [2*POINTS];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;

  logic              accept, commit, load, rd_done;
  logic [ADDR_W-1:0] wr_addr;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  assign in_ready = !full_q[wr_bank_q];
  assign wr_addr  = bitrev(wr_cnt_q);

  always_comb begin
    accept      = in_valid && in_ready;
    commit      = accept && (wr_cnt_q == LAST_IDX);
    load        = (!out_valid_q || out_ready) && full_q[rd_bank_q];
    rd_done     = load && (rd_cnt_q == LAST_IDX);

    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;

    // A full-length frame is committed even without in_last; a short one is dropped.
    if (accept) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      if (commit) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_cnt_d          = '0;
        frame_err_d       = !in_last;
      end else if (in_last) begin
        wr_cnt_d    = '0;
        frame_err_d = 1'b1;
      end
    end

    // Commit and release always target different banks, so both may apply.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[{rd_bank_q, rd_cnt_q}];
      out_index_d = rd_cnt_q;
      out_last_d  = (rd_cnt_q == LAST_IDX);
      rd_cnt_d    = rd_cnt_q + ADDR_W'(1);
      if (rd_done) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_cnt_d          = '0;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[{wr_bank_q, wr_addr}] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_loader.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_fft_bitrev_loader : directed bench for an 8-point and a 1024-point loader.
// Rev 1.0
// =============================================================================
module tb_fft_bitrev_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv8, ir8, il8, ov8, ordy8, ol8, fe8;
  logic [31:0] id8, od8;
  logic [2:0]  oi8;

  logic        iv1k, ir1k, il1k, ov1k, ordy1k, ol1k, fe1k;
  logic [31:0] id1k, od1k;
  logic [9:0]  oi1k;

  fft_bitrev_loader #(.POINTS(8), .DATA_W(32)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_last(il8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_index(oi8),
    .out_last(ol8), .frame_err(fe8)
  );

  fft_bitrev_loader #(.POINTS(1024), .DATA_W(32)) u_dut1k (
    .clk(clk), .rst(rst),
    .in_valid(iv1k), .in_ready(ir1k), .in_data(id1k), .in_last(il1k),
    .out_valid(ov1k), .out_ready(ordy1k), .out_data(od1k), .out_index(oi1k),
    .out_last(ol1k), .frame_err(fe1k)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int          BR8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [32:0] in_q[$];
  logic [31:0] exp_q[$];
  int          exp_k, rdy_mode, fe_cnt, n_out, idle_cnt, inready_low;
  bit          started, stall_q;
  logic [31:0] st_data;
  logic [2:0]  st_idx;
  logic        st_last;
  logic [31:0] got1k[1024];

  task automatic push_frame(input int base, input int last_pos);
    for (int i = 0; i < 8; i++) in_q.push_back({(i == last_pos), 32'(base + i)});
  endtask

  task automatic push_exp(input int base);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(base + BR8[i]));
  endtask

  task automatic clear_stats();
    fe_cnt = 0; n_out = 0; idle_cnt = 0; inready_low = 0; started = 0;
  endtask

  // One clock of the 8-point bench, entered and left on a falling edge.
  task automatic cycle8();
    logic [31:0] e;
    if (stall_q) begin
      check("stall_data", od8, st_data);
      check("stall_index", oi8, st_idx);
      check("stall_last", ol8, st_last);
    end
    if (fe8) fe_cnt++;
    if (!ir8 && in_q.size() > 0) inready_low++;
    if (started && !ov8 && exp_q.size() > 0) idle_cnt++;
    if (ov8) started = 1;
    ordy8 = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (ov8 && ordy8) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_data", od8, e);
        check("out_index", oi8, exp_k);
        check("out_last", ol8, exp_k == 7);
        exp_k = (exp_k + 1) % 8;
      end
      n_out++;
    end
    stall_q = ov8 && !ordy8;
    st_data = od8; st_idx = oi8; st_last = ol8;
    if (in_q.size() > 0) begin
      iv8 = 1'b1;
      {il8, id8} = in_q[0];
      if (ir8) void'(in_q.pop_front());
    end else begin
      iv8 = 1'b0; il8 = 1'b0; id8 = '0;
    end
    @(negedge clk);
  endtask

  task automatic run8(input int budget);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle8();
      n++;
    end
    check("pending_after_run", in_q.size() + exp_q.size(), 0);
    repeat (3) cycle8();
  endtask

  initial begin
    int n, cnt, nout, fe1k_cnt;
    rst = 1'b0;
    iv8 = 0; il8 = 0; id8 = '0; ordy8 = 0;
    iv1k = 0; il1k = 0; id1k = '0; ordy1k = 0;
    exp_k = 0; rdy_mode = 1; stall_q = 0;
    clear_stats();
    repeat (2) @(negedge clk);

    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_frame_err", fe8, 0);
    check("rst_out_last", ol8, 0);
    check("rst_out_index", oi8, 0);
    check("rst_out_data", od8, 0);
    rst = 1'b1;
    @(negedge clk);

    // single frame
    clear_stats(); rdy_mode = 1;
    push_frame(0, 7); push_exp(0);
    run8(200);
    check("t1_count", n_out, 8);
    check("t1_frame_err", fe_cnt, 0);

    // three back-to-back frames, continuous drain
    clear_stats();
    for (int f = 0; f < 3; f++) begin push_frame(8 * f, 7); push_exp(8 * f); end
    run8(300);
    check("t2_count", n_out, 24);
    check("t2_inready_low", inready_low, 0);
    check("t2_out_idle", idle_cnt, 0);
    check("t2_frame_err", fe_cnt, 0);

    // random back-pressure
    clear_stats(); rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin push_frame(24 + 8 * f, 7); push_exp(24 + 8 * f); end
    run8(600);
    check("t3_count", n_out, 24);
    check("t3_frame_err", fe_cnt, 0);

    // short frame then a full one
    clear_stats(); rdy_mode = 1;
    for (int i = 0; i < 5; i++) in_q.push_back({(i == 4), 32'(50 + i)});
    push_frame(100, 7); push_exp(100);
    run8(200);
    check("t4a_count", n_out, 8);
    check("t4a_frame_err", fe_cnt, 1);

    // full-length frame lacking in_last
    clear_stats();
    push_frame(200, 8); push_exp(200);
    run8(200);
    check("t4b_count", n_out, 8);
    check("t4b_frame_err", fe_cnt, 1);

    // both banks filled, partial drain, then asynchronous reset
    clear_stats(); rdy_mode = 0;
    push_frame(0, 7); push_frame(8, 7); push_exp(0);
    n = 0;
    while (in_q.size() > 0 && n < 100) begin cycle8(); n++; end
    iv8 = 1'b0; il8 = 1'b0;
    check("t5_inready_both_full", ir8, 0);
    rdy_mode = 1; n = 0;
    while (n_out < 3 && n < 50) begin cycle8(); n++; end
    check("t5_pre_reset_outputs", n_out, 3);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_out_valid", ov8, 0);
    check("t5_rst_in_ready", ir8, 1);
    check("t5_rst_out_index", oi8, 0);
    check("t5_rst_out_data", od8, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); exp_k = 0; stall_q = 0; clear_stats();
    repeat (12) cycle8();
    check("t5_stale_outputs", n_out, 0);
    push_frame(300, 7); push_exp(300);
    run8(200);
    check("t5_count", n_out, 8);
    check("t5_frame_err", fe_cnt, 0);

    // 1024-point ramp
    cnt = 0; nout = 0; fe1k_cnt = 0; ordy1k = 1'b1;
    for (int c = 0; c < 4000 && nout < 1024; c++) begin
      if (fe1k) fe1k_cnt++;
      if (ov1k) begin got1k[oi1k] = od1k; nout++; end
      if (cnt < 1024) begin
        iv1k = 1'b1; id1k = 32'(cnt); il1k = (cnt == 1023);
        if (ir1k) cnt++;
      end else begin
        iv1k = 1'b0; il1k = 1'b0;
      end
      @(negedge clk);
    end
    check("t6_count", nout, 1024);
    check("t6_frame_err", fe1k_cnt, 0);
    check("t6_k0", got1k[0], 0);
    check("t6_k1", got1k[1], 512);
    check("t6_k3", got1k[3], 768);
    check("t6_k5", got1k[5], 640);
    check("t6_k6", got1k[6], 384);
    check("t6_k512", got1k[512], 1);
    check("t6_k1023", got1k[1023], 1023);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Input reorder stage that sits directly upstream of the radix-2 DIT fft core.
- Accepts a natural-order stream of single-precision samples, one per handshake.
- Writes each sample to its bit-reversed address in a ping-pong (two-bank) buffer.
- Streams each completed frame out in bit-reversed order, so the fft core can start its butterfly stages immediately.
- Double buffering allows one frame to be filled while the previous frame drains.

Parameters:
- POINTS, 1024, frame length. Must be a power of two, ≥ 4.
- DATA_W, 32, sample width (IEEE-754 single). Treated as opaque bits; no arithmetic on the data.
- ADDR_W, $clog2(POINTS), index width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  input sample.
- in_last  in  1  marks the final sample of the input frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream (fft) accepts the sample.
- out_data  out  DATA_W  reordered sample.
- out_index  out  ADDR_W  output position k (0..POINTS-1) within the frame.
- out_last  out  1  high with out_index == POINTS-1.
- frame_err  out  1  one-cycle pulse on an in_last/length mismatch.

Behaviour:
- Reset (rst low, asynchronous), applied immediately:
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_index=0, out_data=0, frame_err=0.
  - State: both bank-full flags cleared, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - Any partial or buffered frame is discarded.
- Storage: two banks of POINTS x DATA_W, synchronous write, synchronous read.
- Write side:
  - in_ready = !full[wr_bank]. This is combinational from the registered flag only; it must not depend on in_valid.
  - On each accept (in_valid && in_ready), store in_data at mem[wr_bank][bitrev(wr_cnt)].
  - Then wr_cnt increments.
- Frame commit: an accept with wr_cnt == POINTS-1 commits the frame:
  - full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
  - If in_last is 0 on that sample, the frame is still committed and frame_err pulses.
- Short frame: an accept with in_last=1 and wr_cnt < POINTS-1:
  - frame_err pulses, wr_cnt <= 0, the bank is not committed, and its contents are overwritten by the next frame.
- Read side:
  - The output register loads when (!out_valid || out_ready) && full[rd_bank].
  - On load: out_data <= mem[rd_bank][rd_cnt], out_index <= rd_cnt, out_last <= (rd_cnt == POINTS-1), out_valid <= 1, rd_cnt increments.
  - Read latency is one cycle from bank-full to first out_valid.
- Bank release: on loading the rd_cnt == POINTS-1 entry, full[rd_bank] <= 0, rd_bank toggles, rd_cnt <= 0.
- Drain: if the register is consumed (out_valid && out_ready) and no load occurs, out_valid <= 0.
- Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Net ordering: output k carries input sample bitrev(k).
- Throughput: one sample per cycle sustained on both sides with continuous traffic.
  - Frame latency: first output valid 2 cycles after the committing write (flag registered, then read).
- Simultaneous events:
  - A commit on one bank and a release of the other bank in the same cycle both take effect.
  - A release makes in_ready rise on the next cycle if the writer was stalled.
  - Write and read never address the same bank concurrently (guarded by the full flags).

Test Plan:
- Reset with POINTS=8 -> in_ready=1, out_valid=0, frame_err=0. Feed samples 0..7 (in_last on 7), out_ready=1 -> outputs 0,4,2,6,1,5,3,7, out_index 0..7, out_last only on the 8th, frame_err never pulses.
- POINTS=8, three back-to-back frames (values 0..23), out_ready=1 -> in_ready stays 1 throughout; each frame is reordered as above (offset 8/16); zero idle cycles on the output after the first frame starts.
- POINTS=8, out_ready toggled pseudo-randomly while feeding 3 frames -> out_data/out_index stable whenever stalled; in_ready drops only when both banks are full; no sample lost or duplicated.
- POINTS=8, in_last on the 5th sample, then a full valid frame 100..107 -> one frame_err pulse; only the 100..107 frame appears, as 100,104,102,106,101,105,103,107. Separately, 8 samples without in_last -> frame output normally plus one frame_err pulse.
- POINTS=8, rst low mid-output (after 3 outputs) with a second frame buffered -> out_valid=0 immediately; after release, no stale data is emitted; a new frame reorders correctly.
- POINTS=1024, ramp 0..1023 -> out_data at index k equals bitrev10(k), e.g. k=1 -> 512, k=3 -> 768, k=1023 -> 1023.
